rng_reader: RTL and testbench

- Consumer side of the free-running RNG path: samples the raw LHCA state word each cycle and conditions it by XOR-folding.
- Runs a continuous repetition-count health test on the raw samples.
- Buffers conditioned words in a small FIFO and hands them to the crypto core over a valid/ready interface.
- Sits between rng_top.out_random_num and the key/nonce consumers.

---
 rtl/rng_reader.sv | 198 +++++++++++++++++++
 tb/tb_rng_reader.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rng_reader.sv
`default_nettype none
// ============================================================================
// Module   : rng_reader
// Brief    : XOR-fold conditioner, repetition-count health test and FWFT
//            output FIFO for the raw LHCA RNG state. Optional macro
//            RNG_APT_EN adds an adaptive-proportion test on raw_i[0].
// Revision : 1.0 - initial release
// ============================================================================
module rng_reader #(
  parameter int WIDTH         = 32,
  parameter int FOLD          = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int WARMUP_CYCLES = 16,
  parameter int RCT_LIMIT     = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en_i,
  input  logic [WIDTH-1:0]                  raw_i,
  input  logic                              clr_fail_i,
  output logic                              rnd_valid_o,
  input  logic                              rnd_ready_i,
  output logic [WIDTH-1:0]                  rnd_data_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level_o,
  output logic                              health_fail_o
);

  localparam int c_lvl_w = $clog2(FIFO_DEPTH+1);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_wrm_w = $clog2(WARMUP_CYCLES+1);
  localparam int c_fld_w = $clog2(FOLD+1);
  localparam int c_run_w = $clog2(RCT_LIMIT+1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WARMUP  = 2'd1,
    S_COLLECT = 2'd2,
    S_FAIL    = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_wrm_w-1:0]   r_warm;
  logic [WIDTH-1:0]     r_acc;
  logic [c_fld_w-1:0]   r_fold;
  logic [WIDTH-1:0]     r_prev;
  logic                 r_prev_ok;
  logic [c_run_w-1:0]   r_run;
  logic                 r_fail;
  logic [WIDTH-1:0]     r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]   r_wptr;
  logic [c_ptr_w-1:0]   r_rptr;
  logic [c_lvl_w-1:0]   r_level;

  logic                 w_pop;
  logic                 w_can_push;
  logic                 w_consume;
  logic                 w_same;
  logic [c_run_w-1:0]   w_run_next;
  logic                 w_rct_trip;
  logic                 w_apt_trip;
  logic                 w_trip;
  logic                 w_fold_done;
  logic                 w_push;
  logic                 w_flush;
  logic                 w_enter_warmup;
  logic [WIDTH-1:0]     w_word;

  assign w_pop          = (r_level != '0) && rnd_ready_i;
  assign w_can_push     = (r_level != c_lvl_w'(FIFO_DEPTH)) || w_pop;
  assign w_consume      = en_i && ((r_state == S_WARMUP) ||
                                   ((r_state == S_COLLECT) && w_can_push));
  assign w_same         = r_prev_ok && (raw_i == r_prev);
  assign w_run_next     = w_same ? r_run + 1'b1 : c_run_w'(1);
  assign w_rct_trip     = w_consume && (w_run_next == c_run_w'(RCT_LIMIT));
  assign w_trip         = w_rct_trip || w_apt_trip;
  assign w_fold_done    = (r_fold == c_fld_w'(FOLD-1));
  assign w_word         = r_acc ^ raw_i;
  // A sample that trips a health test never reaches the FIFO.
  assign w_push         = w_consume && (r_state == S_COLLECT) && w_fold_done && !w_trip;
  assign w_flush        = (r_state == S_FAIL) || w_trip;
  assign w_enter_warmup = en_i && ((r_state == S_IDLE) ||
                                   ((r_state == S_FAIL) && clr_fail_i));

`ifdef RNG_APT_EN
  logic [5:0] r_apt_n;
  logic [6:0] r_apt_ones;
  logic [6:0] w_ones_next;

  assign w_ones_next = r_apt_ones + {6'd0, raw_i[0]};
  assign w_apt_trip  = w_consume && (r_apt_n == 6'd63) &&
                       ((w_ones_next < 7'd16) || (w_ones_next > 7'd48));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_apt_n    <= '0;
      r_apt_ones <= '0;
    end else if (w_enter_warmup) begin
      r_apt_n    <= '0;
      r_apt_ones <= '0;
    end else if (w_consume) begin
      if (r_apt_n == 6'd63) begin
        r_apt_n    <= '0;
        r_apt_ones <= '0;
      end else begin
        r_apt_n    <= r_apt_n + 1'b1;
        r_apt_ones <= w_ones_next;
      end
    end
  end
`else
  assign w_apt_trip = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_warm    <= '0;
      r_acc     <= '0;
      r_fold    <= '0;
      r_prev    <= '0;
      r_prev_ok <= 1'b0;
      r_run     <= '0;
      r_fail    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en_i) r_state <= S_WARMUP;
        end
        S_WARMUP, S_COLLECT: begin
          if (!en_i) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_fold  <= '0;
          end else if (w_consume) begin
            r_prev    <= raw_i;
            r_prev_ok <= 1'b1;
            r_run     <= w_run_next;
            if (w_trip) begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
            end else if (r_state == S_WARMUP) begin
              r_warm <= r_warm + 1'b1;
              if (r_warm == c_wrm_w'(WARMUP_CYCLES-1)) r_state <= S_COLLECT;
            end else if (w_fold_done) begin
              r_acc  <= '0;
              r_fold <= '0;
            end else begin
              r_acc  <= w_word;
              r_fold <= r_fold + 1'b1;
            end
          end
        end
        S_FAIL: begin
          if (clr_fail_i) begin
            r_fail  <= 1'b0;
            r_state <= en_i ? S_WARMUP : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // Every entry into warm-up starts from a clean history.
      if (w_enter_warmup) begin
        r_warm    <= '0;
        r_acc     <= '0;
        r_fold    <= '0;
        r_prev_ok <= 1'b0;
        r_run     <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (w_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + c_lvl_w'(w_push) - c_lvl_w'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  assign rnd_valid_o   = (r_level != '0);
  assign rnd_data_o    = rnd_valid_o ? r_mem[r_rptr] : '0;
  assign fifo_level_o  = r_level;
  assign health_fail_o = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_rng_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_reader
// Brief    : Scoreboard bench for rng_reader with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rng_reader;

  localparam int WIDTH = 32;
  localparam int FOLD  = 4;
  localparam int DEPTH = 4;
  localparam int WARM  = 16;
  localparam int RCT   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en_i = 1'b0;
  logic [WIDTH-1:0]  raw_i = '0;
  logic              clr_fail_i = 1'b0;
  logic              rnd_ready_i = 1'b0;
  logic              rnd_valid_o;
  logic [WIDTH-1:0]  rnd_data_o;
  logic [2:0]        fifo_level_o;
  logic              health_fail_o;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rng_reader #(
    .WIDTH(WIDTH), .FOLD(FOLD), .FIFO_DEPTH(DEPTH),
    .WARMUP_CYCLES(WARM), .RCT_LIMIT(RCT)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .raw_i(raw_i), .clr_fail_i(clr_fail_i),
    .rnd_valid_o(rnd_valid_o), .rnd_ready_i(rnd_ready_i), .rnd_data_o(rnd_data_o),
    .fifo_level_o(fifo_level_o), .health_fail_o(health_fail_o)
  );

  // Reference model: behaviour of one clock edge given the inputs held at it.
  typedef enum {M_IDLE, M_WARM, M_COLL, M_FAIL} mstate_t;
  mstate_t          m_state = M_IDLE;
  int               m_level = 0;
  bit               m_fail = 0;
  int               m_warm_seen = 0;
  logic [WIDTH-1:0] m_fold[$];
  logic [WIDTH-1:0] m_hist = '0;
  bit               m_hist_ok = 0;
  int               m_run = 0;
  int               m_win_n = 0;
  int               m_win_ones = 0;
  bit               m_consumed = 0;
  logic [WIDTH-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_start();
    m_state = M_WARM; m_warm_seen = 0; m_fold.delete();
    m_hist_ok = 0; m_run = 0; m_win_n = 0; m_win_ones = 0;
  endtask

  task automatic m_reset();
    m_state = M_IDLE; m_level = 0; m_fail = 0; m_fold.delete();
    m_hist_ok = 0; m_run = 0; sb.delete();
  endtask

  task automatic model_edge();
    bit pop, trip;
    logic [WIDTH-1:0] w;
    pop = (m_level > 0) && rnd_ready_i;
    m_consumed = 0;
    case (m_state)
      M_IDLE: if (en_i) m_start();
      M_FAIL: if (clr_fail_i) begin
        m_fail = 0;
        if (en_i) m_start(); else m_state = M_IDLE;
      end
      default: begin
        if (!en_i) begin
          m_state = M_IDLE; m_fold.delete();
        end else if (m_state == M_WARM || m_level < DEPTH || pop) begin
          m_consumed = 1;
          m_run = (m_hist_ok && raw_i == m_hist) ? m_run + 1 : 1;
          m_hist = raw_i; m_hist_ok = 1;
          trip = (m_run >= RCT);
`ifdef RNG_APT_EN
          m_win_n++; m_win_ones += int'(raw_i[0]);
          if (m_win_n == 64) begin
            if (m_win_ones < 16 || m_win_ones > 48) trip = 1;
            m_win_n = 0; m_win_ones = 0;
          end
`endif
          if (trip) begin
            m_state = M_FAIL; m_fail = 1; m_level = 0; pop = 0;
            sb.delete(); m_fold.delete();
          end else if (m_state == M_WARM) begin
            m_warm_seen++;
            if (m_warm_seen == WARM) m_state = M_COLL;
          end else begin
            m_fold.push_back(raw_i);
            if (m_fold.size() == FOLD) begin
              w = '0;
              foreach (m_fold[i]) w ^= m_fold[i];
              sb.push_back(w); m_level++; m_fold.delete();
            end
          end
        end
      end
    endcase
    if (pop) m_level--;
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_edge();
    check("level", 32'(fifo_level_o), m_level);
    check("health_fail", 32'(health_fail_o), 32'(m_fail));
    check("valid", 32'(rnd_valid_o), 32'(m_level != 0));
  endtask

  // Monitor: compares the FIFO head with the scoreboard and retires on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (rnd_valid_o) begin
        if (sb.size() == 0) begin
          vectors++; errors++;
          $display("FAIL sb_underflow: DUT presented %h, scoreboard empty at %0t", rnd_data_o, $time);
        end else begin
          check("head_data", rnd_data_o, sb[0]);
          if (rnd_ready_i) void'(sb.pop_front());
        end
      end else begin
        check("idle_data", rnd_data_o, '0);
      end
    end
  end

  int unsigned k;
  int          nwords;
  int          hold;
  logic [31:0] t1_exp [2];
  logic [31:0] kv;

  task automatic run_k(input int n);
    for (int i = 0; i < n; i++) begin
      raw_i = k;
      step();
      if (m_consumed) k++;
    end
  endtask

  initial begin
    t1_exp[0] = 32'h0000_0004;
    t1_exp[1] = 32'h0000_000C;
    #1;
    check("rst_valid", 32'(rnd_valid_o), 0);
    check("rst_data", rnd_data_o, 0);
    check("rst_level", 32'(fifo_level_o), 0);
    check("rst_fail", 32'(health_fail_o), 0);
    @(negedge clk); rst = 1'b0;

    // 1: straight collection with a ready consumer
    en_i = 1'b1; rnd_ready_i = 1'b1; k = 1; nwords = 0;
    for (int i = 0; i < 40; i++) begin
      raw_i = k;
      step();
      if (m_consumed) k++;
      if (fifo_level_o != 0 && nwords < 2) begin
        check("t1_word", rnd_data_o, t1_exp[nwords]);
        nwords++;
      end
    end

    // 2: back-pressure fills the FIFO and stalls sampling
    rnd_ready_i = 1'b0;
    run_k(40);
    check("t2_full_level", 32'(fifo_level_o), DEPTH);
    rnd_ready_i = 1'b1;
    run_k(30);

    // 3: stuck raw value trips the repetition test
    raw_i = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) step();
    check("t3_fail_flag", 32'(health_fail_o), 1);
    check("t3_flushed", 32'(fifo_level_o), 0);
    clr_fail_i = 1'b1; step(); clr_fail_i = 1'b0;
    run_k(30);

    // 4: drop enable mid-fold with a buffered word
    rnd_ready_i = 1'b0;
    for (int i = 0; i < 60 && !(m_level == 1 && m_fold.size() == 2); i++) begin
      raw_i = k; step(); if (m_consumed) k++;
    end
    en_i = 1'b0; step();
    rnd_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) step();
    en_i = 1'b1;
    run_k(30);

    // 5: asynchronous reset between edges with words buffered
    rnd_ready_i = 1'b0;
    for (int i = 0; i < 80 && m_level != 3; i++) begin
      raw_i = k; step(); if (m_consumed) k++;
    end
    #3; rst = 1'b1; #1;
    check("t5_valid", 32'(rnd_valid_o), 0);
    check("t5_level", 32'(fifo_level_o), 0);
    check("t5_data", rnd_data_o, 0);
    check("t5_fail", 32'(health_fail_o), 0);
    m_reset();
    en_i = 1'b0;
    @(negedge clk); rst = 1'b0;

    // 6: raw_i[0] stuck high for a full proportion window
    en_i = 1'b1; rnd_ready_i = 1'b1; k = 1;
    for (int i = 0; i < 80; i++) begin
      kv = k;
      raw_i = {kv[30:0], 1'b1};
      step();
      if (m_consumed) k++;
    end
`ifdef RNG_APT_EN
    check("t6_apt_fail", 32'(health_fail_o), 1);
`else
    check("t6_apt_fail", 32'(health_fail_o), 0);
`endif
    clr_fail_i = 1'b1; step(); clr_fail_i = 1'b0;

    // Randomised phase with occasional stuck bursts
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      en_i        = ($urandom_range(0, 31) != 0);
      rnd_ready_i = $urandom_range(0, 1) == 1;
      clr_fail_i  = ($urandom_range(0, 7) == 0);
      if (hold > 0) hold--;
      else begin
        raw_i = $urandom;
        if ($urandom_range(0, 15) == 0) hold = $urandom_range(3, 10);
      end
      step();
    end

    // Drain
    en_i = 1'b0; clr_fail_i = 1'b0; rnd_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("drain_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
